bitmask_imm_decode_pipe: RTL and testbench

- Pipelined, parametrised decoder for A64 bitmask immediates (N:immr:imms) producing wmask/tmask for logical-immediate and bitfield datapaths.
- Adds width selection (32/64), an operation-size input, reserved-encoding detection, a logical/bitfield mode bit, and a 2-stage valid/ready pipeline with flush.
- Sits between the decode stage and the ALU/bitfield unit in the pipelined core.

---
 rtl/bitmask_imm_decode_pipe_if.sv | 35 +++
 rtl/bitmask_imm_decode_pipe.sv | 140 ++++++++++++++
 tb/tb_bitmask_imm_decode_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitmask_imm_decode_pipe_if.sv
// Request/result bundle for the bitmask immediate decoder.
// master drives requests and consumes results; slave is the decoder.
interface bitmask_imm_decode_pipe_if #(
   parameter int DATAW = 64,
   parameter int TAGW  = 5
);
   logic             in_valid;
   logic             in_ready;
   logic             in_n;
   logic [5:0]       in_immr;
   logic [5:0]       in_imms;
   logic             in_sf;
   logic             in_logical;
   logic [TAGW-1:0]  in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [DATAW-1:0] out_wmask;
   logic [DATAW-1:0] out_tmask;
   logic             out_illegal;
   logic [TAGW-1:0]  out_tag;

   modport master (
      output in_valid, in_n, in_immr, in_imms,
      output in_sf, in_logical, in_tag, out_ready,
      input  in_ready, out_valid, out_wmask,
      input  out_tmask, out_illegal, out_tag
   );

   modport slave (
      input  in_valid, in_n, in_immr, in_imms,
      input  in_sf, in_logical, in_tag, out_ready,
      output in_ready, out_valid, out_wmask,
      output out_tmask, out_illegal, out_tag
   );
endinterface

// File: rtl/bitmask_imm_decode_pipe.sv
// Two-stage elastic decoder for A64 N:immr:imms bitmask immediates.
// Stage 1 extracts element size and fields; stage 2 builds wmask/tmask.
module bitmask_imm_decode_pipe #(
   parameter int DATAW = 64,
   parameter int TAGW  = 5
) (
   input logic clk,
   input logic reset,
   input logic flush,
   bitmask_imm_decode_pipe_if.slave bus
);

   logic            s1_valid;
   logic [5:0]      s1_s;
   logic [5:0]      s1_r;
   logic [5:0]      s1_d;
   logic [5:0]      s1_levels;
   logic            s1_ill;
   logic [TAGW-1:0] s1_tag;

   logic             o_valid;
   logic [DATAW-1:0] o_wmask;
   logic [DATAW-1:0] o_tmask;
   logic             o_ill;
   logic [TAGW-1:0]  o_tag;

   logic s2_advance;
   logic accept;

   logic [6:0] key;
   logic [5:0] levels_c;
   logic [5:0] s_c;
   logic [5:0] r_c;
   logic [5:0] d_c;
   logic       sf_c;
   logic       ill_c;

   logic [DATAW-1:0] wm_c;
   logic [DATAW-1:0] tm_c;

   assign s2_advance   = !o_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_advance;
   assign accept       = bus.in_valid && bus.in_ready;

   assign key  = {bus.in_n, ~bus.in_imms};
   assign sf_c = (DATAW == 64) ? bus.in_sf : 1'b0;

   // Element size from the top set bit of {N,~imms}, then field masking.
   always_comb begin
      levels_c = '0;
      for (int k = 0; k < 7; k++) begin
         if (key[k]) levels_c = 6'((7'd1 << k) - 7'd1);
      end
      s_c   = bus.in_imms & levels_c;
      r_c   = bus.in_immr & levels_c;
      d_c   = (s_c - r_c) & levels_c;
      ill_c = (key == 7'd0)
           || (bus.in_n && !sf_c)
           || ((DATAW == 32) && bus.in_n)
           || (bus.in_logical && (s_c == levels_c));
   end

   // Bit i of the output maps to element bit (i mod esize); the rotated
   // run of S+1 ones covers element bit j when (j+R) mod esize <= S.
   always_comb begin
      wm_c = '0;
      tm_c = '0;
      for (int i = 0; i < DATAW; i++) begin
         logic [5:0] idx;
         logic [5:0] src;
         idx     = 6'(i) & s1_levels;
         src     = (idx + s1_r) & s1_levels;
         wm_c[i] = (src <= s1_s) && !s1_ill;
         tm_c[i] = (idx <= s1_d) && !s1_ill;
      end
   end

   // Stage 1 occupancy: flush kills, otherwise refill whenever it drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
      end
   end

   // Stage 1 payload captured on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_s      <= '0;
         s1_r      <= '0;
         s1_d      <= '0;
         s1_levels <= '0;
         s1_ill    <= 1'b0;
         s1_tag    <= '0;
      end else if (accept) begin
         s1_s      <= s_c;
         s1_r      <= r_c;
         s1_d      <= d_c;
         s1_levels <= levels_c;
         s1_ill    <= ill_c;
         s1_tag    <= bus.in_tag;
      end
   end

   // Output occupancy: advances from stage 1 unless stalled or flushed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid <= 1'b0;
      end else if (flush) begin
         o_valid <= 1'b0;
      end else if (s2_advance) begin
         o_valid <= s1_valid;
      end
   end

   // Output payload held stable while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_wmask <= '0;
         o_tmask <= '0;
         o_ill   <= 1'b0;
         o_tag   <= '0;
      end else if (s2_advance && s1_valid) begin
         o_wmask <= wm_c;
         o_tmask <= tm_c;
         o_ill   <= s1_ill;
         o_tag   <= s1_tag;
      end
   end

   assign bus.out_valid   = o_valid;
   assign bus.out_wmask   = o_wmask;
   assign bus.out_tmask   = o_tmask;
   assign bus.out_illegal = o_ill;
   assign bus.out_tag     = o_tag;

endmodule

// File: tb/tb_bitmask_imm_decode_pipe.sv
// Bench for bitmask_imm_decode_pipe: known vectors on 64- and 32-bit
// instances, random traffic against a reference model, stall/flush/reset.
module tb_bitmask_imm_decode_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   bitmask_imm_decode_pipe_if #(.DATAW(64), .TAGW(5)) i64 ();
   bitmask_imm_decode_pipe_if #(.DATAW(32), .TAGW(5)) i32 ();

   bitmask_imm_decode_pipe #(.DATAW(64), .TAGW(5)) dut64 (
      .clk(clk), .reset(rst), .flush(flush), .bus(i64)
   );
   bitmask_imm_decode_pipe #(.DATAW(32), .TAGW(5)) dut32 (
      .clk(clk), .reset(rst), .flush(flush), .bus(i32)
   );

   int nchk = 0;
   int nfail = 0;

   typedef struct {
      logic [63:0] wm;
      logic [63:0] tm;
      logic        ill;
      logic [4:0]  tag;
   } exp_t;

   exp_t q64[$];
   exp_t q32[$];

   logic        hold_pend = 1'b0;
   logic [63:0] hwm;
   logic [63:0] htm;
   logic [4:0]  htag;

   typedef struct {
      logic        n;
      logic [5:0]  immr;
      logic [5:0]  imms;
      logic        sf;
      logic        lg;
      logic [63:0] wm64;
      logic [63:0] tm64;
      logic        ill64;
      logic [31:0] wm32;
      logic [31:0] tm32;
      logic        ill32;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference: element of S+1 ones rotated right by R inside esize bits,
   // then tiled across the datapath width.
   function automatic void model(
      input logic n, input logic [5:0] immr, input logic [5:0] imms,
      input logic sf, input logic lg, input int dw,
      output logic [63:0] wm, output logic [63:0] tm, output logic ill);
      logic [6:0]   key;
      int           len, es, s, r, d;
      logic [127:0] emask, ones_s, rot, tel;
      key = {n, ~imms};
      len = -1;
      for (int k = 0; k < 7; k++) if (key[k]) len = k;
      wm = '0;
      tm = '0;
      if (len < 0) begin
         ill = 1'b1;
         return;
      end
      es  = 1 << len;
      s   = int'(imms) % es;
      r   = int'(immr) % es;
      d   = (s - r + es) % es;
      ill = (n && (dw == 32 || !sf)) || (lg && s == es - 1);
      if (ill) return;
      emask  = (128'd1 << es) - 128'd1;
      ones_s = (128'd1 << (s + 1)) - 128'd1;
      rot    = ((ones_s >> r) | (ones_s << (es - r))) & emask;
      tel    = (128'd1 << (d + 1)) - 128'd1;
      for (int k = 0; k < dw; k += es) begin
         wm |= 64'(rot << k);
         tm |= 64'(tel << k);
      end
   endfunction

   task automatic drive(input logic v, input logic r, input logic fl,
                        input logic n, input logic [5:0] immr,
                        input logic [5:0] imms, input logic sf,
                        input logic lg, input logic [4:0] tag);
      flush          = fl;
      i64.in_valid   = v;
      i64.out_ready  = r;
      i64.in_n       = n;
      i64.in_immr    = immr;
      i64.in_imms    = imms;
      i64.in_sf      = sf;
      i64.in_logical = lg;
      i64.in_tag     = tag;
      i32.in_valid   = v;
      i32.out_ready  = r;
      i32.in_n       = n;
      i32.in_immr    = immr;
      i32.in_imms    = imms;
      i32.in_sf      = 1'b0;
      i32.in_logical = lg;
      i32.in_tag     = tag;
   endtask

   task automatic pop_chk(input string nm, ref exp_t q[$],
                          input logic [63:0] wm, input logic [63:0] tm,
                          input logic ill, input logic [4:0] tag);
      exp_t e;
      if (q.size() == 0) begin
         nchk++;
         nfail++;
         $display("FAIL %s_unexpected: got tag %h expected none", nm, tag);
      end else begin
         e = q.pop_front();
         chk({nm, "_tag"}, 64'(tag), 64'(e.tag));
         chk({nm, "_wm"}, wm, e.wm);
         chk({nm, "_tm"}, tm, e.tm);
         chk({nm, "_ill"}, 64'(ill), 64'(e.ill));
      end
   endtask

   // One cycle of traffic; handshakes are observed 1 ns after the falling
   // edge and take effect on the following rising edge.
   task automatic cyc(input logic v, input logic r, input logic fl,
                      input logic [4:0] tag, output logic rdy);
      logic        n, sf, lg;
      logic [5:0]  immr, imms;
      exp_t        e;
      n    = 1'($urandom);
      sf   = ($urandom_range(0, 3) != 0);
      lg   = 1'($urandom);
      immr = 6'($urandom);
      imms = 6'($urandom);
      @(negedge clk);
      drive(v, r, fl, n, immr, imms, sf, lg, tag);
      #1;
      rdy = i64.in_ready;
      if (hold_pend) begin
         chk("stall_valid", 64'(i64.out_valid), 64'd1);
         chk("stall_wm", i64.out_wmask, hwm);
         chk("stall_tm", i64.out_tmask, htm);
         chk("stall_tag", 64'(i64.out_tag), 64'(htag));
      end
      if (i64.out_valid && i64.out_ready)
         pop_chk("r64", q64, i64.out_wmask, i64.out_tmask,
                 i64.out_illegal, i64.out_tag);
      if (i32.out_valid && i32.out_ready)
         pop_chk("r32", q32, 64'(i32.out_wmask), 64'(i32.out_tmask),
                 i32.out_illegal, i32.out_tag);
      if (fl) begin
         q64.delete();
         q32.delete();
      end else begin
         if (i64.in_valid && i64.in_ready) begin
            model(n, immr, imms, sf, lg, 64, e.wm, e.tm, e.ill);
            e.tag = tag;
            q64.push_back(e);
         end
         if (i32.in_valid && i32.in_ready) begin
            model(n, immr, imms, 1'b0, lg, 32, e.wm, e.tm, e.ill);
            e.tag = tag;
            q32.push_back(e);
         end
      end
      hold_pend = !fl && i64.out_valid && !i64.out_ready;
      hwm  = i64.out_wmask;
      htm  = i64.out_tmask;
      htag = i64.out_tag;
   endtask

   task automatic drain();
      logic rdy;
      for (int k = 0; k < 20; k++) begin
         if (q64.size() == 0 && q32.size() == 0) break;
         cyc(1'b0, 1'b1, 1'b0, 5'd0, rdy);
      end
      chk("drain64", 64'(q64.size()), 64'd0);
      chk("drain32", 64'(q32.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rdy;
      int   lat;
      int   sent;

      tbl[0] = '{1'b1, 6'd0, 6'b000000, 1'b1, 1'b1,
                 64'h0000000000000001, 64'h0000000000000001, 1'b0,
                 32'h0, 32'h0, 1'b1};
      tbl[1] = '{1'b0, 6'd0, 6'b111100, 1'b1, 1'b1,
                 64'h5555555555555555, 64'h5555555555555555, 1'b0,
                 32'h55555555, 32'h55555555, 1'b0};
      tbl[2] = '{1'b0, 6'd1, 6'b000111, 1'b1, 1'b1,
                 64'h8000007F8000007F, 64'h0000007F0000007F, 1'b0,
                 32'h8000007F, 32'h0000007F, 1'b0};
      tbl[3] = '{1'b1, 6'd0, 6'b111111, 1'b1, 1'b1,
                 64'h0, 64'h0, 1'b1, 32'h0, 32'h0, 1'b1};
      tbl[4] = '{1'b1, 6'd0, 6'b111111, 1'b1, 1'b0,
                 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0,
                 32'h0, 32'h0, 1'b1};
      tbl[5] = '{1'b0, 6'd0, 6'b111111, 1'b1, 1'b1,
                 64'h0, 64'h0, 1'b1, 32'h0, 32'h0, 1'b1};
      tbl[6] = '{1'b1, 6'd0, 6'b000000, 1'b0, 1'b1,
                 64'h0, 64'h0, 1'b1, 32'h0, 32'h0, 1'b1};
      tbl[7] = '{1'b0, 6'd3, 6'b011110, 1'b1, 1'b1,
                 64'hEFFFFFFFEFFFFFFF, 64'h0FFFFFFF0FFFFFFF, 1'b0,
                 32'hEFFFFFFF, 32'h0FFFFFFF, 1'b0};
      tbl[8] = '{1'b1, 6'd8, 6'b000011, 1'b1, 1'b0,
                 64'h0F00000000000000, 64'h0FFFFFFFFFFFFFFF, 1'b0,
                 32'h0, 32'h0, 1'b1};

      drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 5'd0);
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(i64.out_valid), 64'd0);
      chk("rst_wm", i64.out_wmask, 64'd0);
      chk("rst_tm", i64.out_tmask, 64'd0);
      chk("rst_ill", 64'(i64.out_illegal), 64'd0);
      chk("rst_tag", 64'(i64.out_tag), 64'd0);
      chk("rst_valid32", 64'(i32.out_valid), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 1'b0, tbl[i].n, tbl[i].immr, tbl[i].imms,
               tbl[i].sf, tbl[i].lg, 5'(i));
         @(posedge clk);
         @(negedge clk);
         drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 5'd0);
         lat = 1;
         while (!i64.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
         end
         #1;
         chk("vec_latency", 64'(lat), 64'd2);
         chk("vec_valid32", 64'(i32.out_valid), 64'd1);
         chk("vec_tag", 64'(i64.out_tag), 64'(i));
         chk("vec_wm64", i64.out_wmask, tbl[i].wm64);
         chk("vec_tm64", i64.out_tmask, tbl[i].tm64);
         chk("vec_ill64", 64'(i64.out_illegal), 64'(tbl[i].ill64));
         chk("vec_wm32", 64'(i32.out_wmask), 64'(tbl[i].wm32));
         chk("vec_tm32", 64'(i32.out_tmask), 64'(tbl[i].tm32));
         chk("vec_ill32", 64'(i32.out_illegal), 64'(tbl[i].ill32));
      end
      cyc(1'b0, 1'b1, 1'b0, 5'd0, rdy);
      drain();

      sent = 0;
      for (int c = 0; c < 16; c++) begin
         logic v;
         v = (sent < 8);
         cyc(v, !(c >= 3 && c <= 6), 1'b0, 5'(10 + sent), rdy);
         if (c == 4) chk("stall_in_ready", 64'(rdy), 64'd0);
         if (c == 7) chk("resume_in_ready", 64'(rdy), 64'd1);
         if (v && rdy) sent++;
      end
      chk("stall_sent", 64'(sent), 64'd8);
      drain();

      cyc(1'b1, 1'b1, 1'b0, 5'd21, rdy);
      cyc(1'b1, 1'b0, 1'b0, 5'd22, rdy);
      cyc(1'b1, 1'b0, 1'b1, 5'd23, rdy);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 5'd0, rdy);
         chk("flush_valid", 64'(i64.out_valid), 64'd0);
      end
      cyc(1'b1, 1'b1, 1'b1, 5'd24, rdy);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 5'd0, rdy);
         chk("flush_drop_valid", 64'(i64.out_valid), 64'd0);
      end

      for (int k = 0; k < 300; k++) begin
         logic fl, r;
         fl = ($urandom_range(0, 31) == 0);
         r  = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
         cyc($urandom_range(0, 9) < 7, r, fl, 5'($urandom), rdy);
      end
      drain();

      cyc(1'b1, 1'b1, 1'b0, 5'd1, rdy);
      cyc(1'b1, 1'b1, 1'b0, 5'd2, rdy);
      cyc(1'b1, 1'b0, 1'b0, 5'd3, rdy);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(i64.out_valid), 64'd0);
      chk("midrst_valid32", 64'(i32.out_valid), 64'd0);
      chk("midrst_wm", i64.out_wmask, 64'd0);
      chk("midrst_in_ready", 64'(i64.in_ready), 64'd1);
      q64.delete();
      q32.delete();
      hold_pend = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 5'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         cyc(1'b0, 1'b1, 1'b0, 5'd0, rdy);
         chk("postrst_valid", 64'(i64.out_valid), 64'd0);
      end
      cyc(1'b1, 1'b1, 1'b0, 5'd9, rdy);
      cyc(1'b0, 1'b1, 1'b0, 5'd0, rdy);
      chk("postrst_q", 64'(q64.size()), 64'd1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
